wdt_multi: RTL and testbench
============================

WDT_MULTI -- requirements
Module: wdt_multi

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning number of independent watchdog channels (1..8).
REQ-002 SHALL have parameter CW, default 16, meaning frame/service/reset counter width (8..16).
REQ-003 SHALL have parameter AW, default 20, meaning ADC_IN width.
REQ-004 SHALL have parameter BO_THRESH, default 20'h80000, meaning brownout threshold.
REQ-005 SHALL have parameter WR_WIN, default 4, meaning config-write window length in cycles after unlock.
REQ-006 SHALL have port CLK, input, 1 bit: the single clock. All logic is on the rising edge.
REQ-007 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port ABUS, input, 5 bits: [4:2] channel select, [1:0] register select (0 FRAME, 1 SVC, 2 CTRL, 3 RLIM).
REQ-009 SHALL have port DBUS, input, 16 bits: data, sampled every cycle.
REQ-010 SHALL have port ADC_IN, input, AW bits: supply voltage sample.
REQ-011 SHALL have port RSTOUT, output, NCH bits: per-channel reset request.
REQ-012 SHALL have port WDFAIL, output, NCH bits: per-channel fault-limit reached (sticky).
REQ-013 SHALL have port FLSTAT, output, 2*NCH bits: per-channel status (00 ok, 01 early, 10 late, 11 brownout).
REQ-014 SHALL have port BROWNOUT, output, 1 bit: filtered brownout flag.

Function
REQ-015 Unlock: DBUS==16'hAAAA SHALL arm; arm holds while DBUS stays AAAA; DBUS==16'h5555 while armed SHALL open the write window; any other value SHALL disarm.
REQ-016 The write window SHALL last WR_WIN cycles, starting the cycle after 5555. A new unlock inside the window SHALL restart it.
REQ-017 FRAME, SVC and RLIM writes (DBUS[CW-1:0] to the channel selected by ABUS) SHALL take effect only inside the window; outside it they SHALL be ignored.
REQ-018 CTRL writes SHALL be accepted in any cycle; DBUS[4]=INIT and DBUS[3]=KICK. DBUS==0 SHALL be a no-op. A channel select >= NCH SHALL be ignored.
REQ-019 Each channel SHALL run a state machine with states IDLE, RUN and FAULT.
REQ-020 IDLE->RUN on INIT, only if FRAME!=0. The frame counter SHALL clear to 0 and FLSTAT SHALL go to 00.
REQ-021 In RUN the counter SHALL increment by 1 each cycle. KICK with count<SVC SHALL be an early fault (01). KICK with SVC<=count<=FRAME SHALL be a valid service: counter cleared to 0, FLSTAT 00.
REQ-022 In RUN, reaching count==FRAME without a KICK SHALL produce a late fault (10) on the next cycle. A KICK in the same cycle as count==FRAME SHALL count as valid.
REQ-023 A fault SHALL cause RUN->FAULT. RSTOUT SHALL assert the following cycle, the down-counter SHALL load RLIM, and RSTOUT SHALL hold for RLIM+1 cycles. On reaching 0 the channel SHALL go to RUN with counter 0, and FLSTAT SHALL hold until the next valid kick or INIT.
REQ-024 In FAULT, KICK SHALL be ignored. INIT SHALL be deferred until FAULT exits.
REQ-025 INIT while in RUN SHALL restart the counter at 0 and clear FLSTAT.
REQ-026 A per-channel 2-bit fault counter SHALL saturate at 3. WDFAIL SHALL set on the third fault and clear only on RST.
REQ-027 SVC>FRAME is legal: every kick is then early.

Reset
REQ-028 While RST is high: all channels in IDLE; FRAME, SVC, RLIM, counters and fault counts = 0; window closed and disarmed.
REQ-029 While RST is high: RSTOUT=0, WDFAIL=0, FLSTAT=0, BROWNOUT=0.
REQ-030 RST asserted mid-FAULT SHALL drop RSTOUT on the next edge.

Configuration
REQ-031 With WDT_BROWNOUT_EN defined, ADC_IN<BO_THRESH for 4 consecutive cycles SHALL set BROWNOUT.
REQ-032 With WDT_BROWNOUT_EN defined, ADC_IN>=BO_THRESH for 4 consecutive cycles SHALL clear BROWNOUT.
REQ-033 With WDT_BROWNOUT_EN defined, a BROWNOUT rising edge SHALL force every RUN channel into FAULT with FLSTAT=11.
REQ-034 Without WDT_BROWNOUT_EN, BROWNOUT SHALL be tied 0, ADC_IN ignored, and code 11 never produced.

Structure
REQ-035 Package wdt_pkg SHALL hold the channel state enum, FLSTAT codes, register address constants and unlock keys AAAA/5555.
REQ-036 Per-channel logic SHALL be sub-module wdt_chan, instantiated NCH times via generate. Unlock, decode and brownout SHALL stay in wdt_multi.

Verification
REQ-037 The bench SHALL cover: 3636, AAAA x3, 5555, then FRAME=0A/SVC=03/RLIM=04 to ch0 -> registers hold those values; a write 5 cycles after unlock is ignored.
REQ-038 The bench SHALL cover: INIT ch0, KICK at count 1 -> FLSTAT[1:0]=01, RSTOUT[0] high exactly 5 cycles, then RUN.
REQ-039 The bench SHALL cover: INIT ch0, KICK at counts 5 and 10 -> FLSTAT 00, no RSTOUT.
REQ-040 The bench SHALL cover: INIT ch0, no kick -> late fault at count 0A, FLSTAT=10; three such faults -> WDFAIL[0]=1; ch1 unaffected.
REQ-041 The bench SHALL cover (with WDT_BROWNOUT_EN): ADC_IN=20'h10000 for 4 cycles -> BROWNOUT=1, all running channels FLSTAT=11 and RSTOUT asserted.
REQ-042 The bench SHALL cover: RST mid-FAULT -> all outputs 0 next edge; unlock sequence AAAA,1111,5555 -> no window opens.

Source files
------------

// File: rtl/wdt_pkg.sv
// Shared types and constants for the multi-channel watchdog: channel states,
// status codes, register addresses and the unlock keys.
package wdt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } chan_state_e;

    typedef enum logic [1:0] {
        FL_OK    = 2'b00,
        FL_EARLY = 2'b01,
        FL_LATE  = 2'b10,
        FL_BROWN = 2'b11
    } flstat_e;

    localparam logic [1:0] REG_FRAME = 2'd0;
    localparam logic [1:0] REG_SVC   = 2'd1;
    localparam logic [1:0] REG_CTRL  = 2'd2;
    localparam logic [1:0] REG_RLIM  = 2'd3;

    localparam logic [15:0] KEY_ARM  = 16'hAAAA;
    localparam logic [15:0] KEY_OPEN = 16'h5555;

    localparam int CTRL_INIT_BIT = 4;
    localparam int CTRL_KICK_BIT = 3;

endpackage

// File: rtl/wdt_chan.sv
// One watchdog channel: FRAME/SVC/RLIM registers, IDLE/RUN/FAULT state machine,
// reset-pulse down-counter and sticky fault-limit flag.
module wdt_chan
    import wdt_pkg::*;
#(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_frame,
    input  logic          wr_svc,
    input  logic          wr_rlim,
    input  logic [CW-1:0] wr_data,
    input  logic          init,
    input  logic          kick,
    input  logic          bo_evt,
    output logic          rstout,
    output logic          wdfail,
    output logic [1:0]    flstat
);

    chan_state_e   state;
    flstat_e       fl_q;
    flstat_e       fault_code;
    logic          fault_now;
    logic [CW-1:0] frame;
    logic [CW-1:0] svc;
    logic [CW-1:0] rlim;
    logic [CW-1:0] cnt;
    logic [CW-1:0] rcnt;
    logic [1:0]    fcnt;
    logic          init_pend;

    assign flstat = fl_q;

    // NOTE: every output of always_comb is defaulted first so no path leaves a latch.
    always_comb begin
        fault_now  = 1'b0;
        fault_code = FL_OK;
        if (state == ST_RUN) begin
            if (bo_evt) begin
                fault_now  = 1'b1;
                fault_code = FL_BROWN;
            end else if (!init) begin
                if (kick && cnt < svc) begin
                    fault_now  = 1'b1;
                    fault_code = FL_EARLY;
                end else if (kick ? (cnt > frame) : (cnt >= frame)) begin
                    fault_now  = 1'b1;
                    fault_code = FL_LATE;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignment so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            fl_q      <= FL_OK;
            frame     <= '0;
            svc       <= '0;
            rlim      <= '0;
            cnt       <= '0;
            rcnt      <= '0;
            fcnt      <= '0;
            init_pend <= 1'b0;
            rstout    <= 1'b0;
            wdfail    <= 1'b0;
        end else begin
            if (wr_frame) frame <= wr_data;
            if (wr_svc)   svc   <= wr_data;
            if (wr_rlim)  rlim  <= wr_data;

            case (state)
                ST_IDLE: begin
                    if (init && frame != '0) begin
                        state <= ST_RUN;
                        cnt   <= '0;
                        fl_q  <= FL_OK;
                    end
                end
                ST_RUN: begin
                    if (fault_now) begin
                        state  <= ST_FAULT;
                        fl_q   <= fault_code;
                        rstout <= 1'b1;
                        rcnt   <= rlim;
                        if (fcnt != 2'd3) fcnt <= fcnt + 2'd1;
                        if (fcnt >= 2'd2) wdfail <= 1'b1;
                    end else if (init || kick) begin
                        cnt  <= '0;
                        fl_q <= FL_OK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_FAULT: begin
                    // INIT seen during the reset pulse is held and applied on exit.
                    if (rcnt == '0) begin
                        state     <= ST_RUN;
                        cnt       <= '0;
                        rstout    <= 1'b0;
                        init_pend <= 1'b0;
                        if (init_pend || init) fl_q <= FL_OK;
                    end else begin
                        rcnt <= rcnt - 1'b1;
                        if (init) init_pend <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/wdt_multi.sv
// Multi-channel watchdog top: unlock sequencer, write window, address decode and
// optional brownout filter (enabled by defining WDT_BROWNOUT_EN).
module wdt_multi
    import wdt_pkg::*;
#(
    parameter int              NCH       = 4,
    parameter int              CW        = 16,
    parameter int              AW        = 20,
    parameter logic [AW-1:0]   BO_THRESH = 20'h80000,
    parameter int              WR_WIN    = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [4:0]        ABUS,
    input  logic [15:0]       DBUS,
    input  logic [AW-1:0]     ADC_IN,
    output logic [NCH-1:0]    RSTOUT,
    output logic [NCH-1:0]    WDFAIL,
    output logic [2*NCH-1:0]  FLSTAT,
    output logic              BROWNOUT
);

    localparam int WW = $clog2(WR_WIN + 1);

    logic          armed;
    logic [WW-1:0] win_cnt;
    logic          win_open;
    logic [2:0]    ch_sel;
    logic [1:0]    reg_sel;
    logic          ch_ok;
    logic          bo_evt;

    assign win_open = (win_cnt != '0);
    assign ch_sel   = ABUS[4:2];
    assign reg_sel  = ABUS[1:0];
    assign ch_ok    = (32'(ch_sel) < NCH);

    // A later 5555 overrides the countdown, which restarts an open window.
    always_ff @(posedge CLK) begin
        if (RST) begin
            armed   <= 1'b0;
            win_cnt <= '0;
        end else begin
            if (win_open) win_cnt <= win_cnt - 1'b1;
            if (DBUS == KEY_ARM) begin
                armed <= 1'b1;
            end else begin
                armed <= 1'b0;
                if (armed && DBUS == KEY_OPEN) win_cnt <= WW'(WR_WIN);
            end
        end
    end

`ifdef WDT_BROWNOUT_EN
    logic [1:0] lo_cnt;
    logic [1:0] hi_cnt;
    logic       adc_low;

    assign adc_low = (ADC_IN < BO_THRESH);
    // Fires on the same edge BROWNOUT rises so running channels fault together with it.
    assign bo_evt  = !BROWNOUT && adc_low && (lo_cnt == 2'd3);

    always_ff @(posedge CLK) begin
        if (RST) begin
            lo_cnt   <= '0;
            hi_cnt   <= '0;
            BROWNOUT <= 1'b0;
        end else if (adc_low) begin
            hi_cnt <= '0;
            if (lo_cnt == 2'd3) BROWNOUT <= 1'b1;
            else                lo_cnt   <= lo_cnt + 2'd1;
        end else begin
            lo_cnt <= '0;
            if (hi_cnt == 2'd3) BROWNOUT <= 1'b0;
            else                hi_cnt   <= hi_cnt + 2'd1;
        end
    end
`else
    logic unused_adc;

    assign unused_adc = ^{ADC_IN, BO_THRESH};
    assign bo_evt     = 1'b0;
    assign BROWNOUT   = 1'b0;
`endif

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        logic sel;
        logic ctrl_hit;

        assign sel      = ch_ok && (ch_sel == 3'(i));
        assign ctrl_hit = sel && (reg_sel == REG_CTRL) && (DBUS != '0);

        wdt_chan #(.CW(CW)) u_chan (
            .clk      (CLK),
            .rst      (RST),
            .wr_frame (sel && win_open && reg_sel == REG_FRAME),
            .wr_svc   (sel && win_open && reg_sel == REG_SVC),
            .wr_rlim  (sel && win_open && reg_sel == REG_RLIM),
            .wr_data  (DBUS[CW-1:0]),
            .init     (ctrl_hit && DBUS[CTRL_INIT_BIT]),
            .kick     (ctrl_hit && DBUS[CTRL_KICK_BIT]),
            .bo_evt   (bo_evt),
            .rstout   (RSTOUT[i]),
            .wdfail   (WDFAIL[i]),
            .flstat   (FLSTAT[2*i +: 2])
        );
    end

endmodule

// File: tb/tb_wdt_multi.sv
// Directed bench for wdt_multi: configuration window, early/valid/late service,
// fault limit, reset during FAULT, unlock rejection and brownout (WDT_BROWNOUT_EN).
module tb_wdt_multi;
    import wdt_pkg::*;

`ifdef WDT_BROWNOUT_EN
    localparam bit BO_EN = 1'b1;
`else
    localparam bit BO_EN = 1'b0;
`endif

    localparam logic [4:0] ABUS_IDLE = {3'd7, REG_FRAME};

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [4:0]  ABUS = ABUS_IDLE;
    logic [15:0] DBUS = 16'h0000;
    logic [19:0] ADC_IN = 20'hFFFFF;
    logic [3:0]  RSTOUT;
    logic [3:0]  WDFAIL;
    logic [7:0]  FLSTAT;
    logic        BROWNOUT;

    int n_tests = 0;
    int n_fail  = 0;

    wdt_multi dut (
        .CLK      (CLK),
        .RST      (RST),
        .ABUS     (ABUS),
        .DBUS     (DBUS),
        .ADC_IN   (ADC_IN),
        .RSTOUT   (RSTOUT),
        .WDFAIL   (WDFAIL),
        .FLSTAT   (FLSTAT),
        .BROWNOUT (BROWNOUT)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [4:0] a, input logic [15:0] d);
        ABUS = a;
        DBUS = d;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(ABUS_IDLE, 16'h0000);
    endtask

    task automatic ctrl(input logic [2:0] ch, input logic [15:0] d);
        drive({ch, REG_CTRL}, d);
    endtask

    task automatic unlock();
        drive(ABUS_IDLE, 16'h3636);
        drive(ABUS_IDLE, 16'hAAAA);
        drive(ABUS_IDLE, 16'hAAAA);
        drive(ABUS_IDLE, 16'hAAAA);
        drive(ABUS_IDLE, 16'h5555);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        idle(3);
        n_tests++;
        if ({RSTOUT, WDFAIL, FLSTAT, BROWNOUT} !== 17'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", {RSTOUT, WDFAIL, FLSTAT, BROWNOUT});
        end
        n_tests++;
        if (dut.g_chan[0].u_chan.state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d want %0d", dut.g_chan[0].u_chan.state, ST_IDLE);
        end
        RST = 1'b0;
        idle(1);
    endtask

    task automatic test_config();
        unlock();
        drive({3'd0, REG_FRAME}, 16'h000A);
        drive({3'd0, REG_SVC},   16'h0003);
        drive({3'd0, REG_RLIM},  16'h0004);
        idle(1);
        drive({3'd0, REG_FRAME}, 16'h0055);
        idle(1);
        n_tests++;
        if (dut.g_chan[0].u_chan.frame !== 16'h000A) begin
            n_fail++;
            $display("FAIL cfg_frame: got %h want 000a", dut.g_chan[0].u_chan.frame);
        end
        n_tests++;
        if (dut.g_chan[0].u_chan.svc !== 16'h0003) begin
            n_fail++;
            $display("FAIL cfg_svc: got %h want 0003", dut.g_chan[0].u_chan.svc);
        end
        n_tests++;
        if (dut.g_chan[0].u_chan.rlim !== 16'h0004) begin
            n_fail++;
            $display("FAIL cfg_rlim: got %h want 0004", dut.g_chan[0].u_chan.rlim);
        end
    endtask

    task automatic test_late();
        int n;
        bit seen_low;
        ctrl(3'd0, 16'h0010);
        idle(10);
        n_tests++;
        if (RSTOUT[0] !== 1'b0 || FLSTAT[1:0] !== 2'b00) begin
            n_fail++;
            $display("FAIL late_at_frame: got rst=%b fl=%b want rst=0 fl=00", RSTOUT[0], FLSTAT[1:0]);
        end
        idle(1);
        n_tests++;
        if (RSTOUT[0] !== 1'b1 || FLSTAT[1:0] !== 2'b10 || WDFAIL[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL late_fault1: got rst=%b fl=%b wdf=%b want 1 10 0", RSTOUT[0], FLSTAT[1:0], WDFAIL[0]);
        end
        for (int k = 2; k <= 3; k++) begin
            n = 0;
            seen_low = 1'b0;
            while (n < 40 && !(seen_low && RSTOUT[0])) begin
                idle(1);
                n++;
                if (!RSTOUT[0]) seen_low = 1'b1;
            end
            n_tests++;
            if (n != 16) begin
                n_fail++;
                $display("FAIL late_period%0d: got %0d cycles want 16", k, n);
            end
            n_tests++;
            if (WDFAIL[0] !== (k == 3)) begin
                n_fail++;
                $display("FAIL late_wdfail%0d: got %b want %b", k, WDFAIL[0], k == 3);
            end
        end
        n_tests++;
        if (RSTOUT[1] !== 1'b0 || WDFAIL[1] !== 1'b0 || FLSTAT[3:2] !== 2'b00) begin
            n_fail++;
            $display("FAIL late_ch1: got rst=%b wdf=%b fl=%b want 0 0 00", RSTOUT[1], WDFAIL[1], FLSTAT[3:2]);
        end
        n = 0;
        while (RSTOUT[0] && n < 10) begin
            idle(1);
            n++;
        end
        n_tests++;
        if (n != 5) begin
            n_fail++;
            $display("FAIL late_pulse: got %0d cycles want 5", n);
        end
    endtask

    task automatic test_early();
        int hi;
        ctrl(3'd0, 16'h0010);
        n_tests++;
        if (FLSTAT[1:0] !== 2'b00) begin
            n_fail++;
            $display("FAIL early_init: got fl=%b want 00", FLSTAT[1:0]);
        end
        idle(1);
        ctrl(3'd0, 16'h0008);
        n_tests++;
        if (FLSTAT[1:0] !== 2'b01 || RSTOUT[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL early_fault: got fl=%b rst=%b want 01 1", FLSTAT[1:0], RSTOUT[0]);
        end
        hi = 1;
        for (int i = 0; i < 10 && RSTOUT[0]; i++) begin
            idle(1);
            if (RSTOUT[0]) hi++;
        end
        n_tests++;
        if (hi != 5) begin
            n_fail++;
            $display("FAIL early_pulse: got %0d cycles want 5", hi);
        end
        n_tests++;
        if (dut.g_chan[0].u_chan.state !== ST_RUN || FLSTAT[1:0] !== 2'b01) begin
            n_fail++;
            $display("FAIL early_exit: got st=%0d fl=%b want %0d 01", dut.g_chan[0].u_chan.state, FLSTAT[1:0], ST_RUN);
        end
    endtask

    task automatic test_valid();
        bit rst_seen = 1'b0;
        ctrl(3'd0, 16'h0010);
        n_tests++;
        if (FLSTAT[1:0] !== 2'b00) begin
            n_fail++;
            $display("FAIL valid_init: got fl=%b want 00", FLSTAT[1:0]);
        end
        for (int i = 0; i < 5; i++) begin
            idle(1);
            rst_seen |= RSTOUT[0];
        end
        ctrl(3'd0, 16'h0008);
        rst_seen |= RSTOUT[0];
        n_tests++;
        if (FLSTAT[1:0] !== 2'b00 || dut.g_chan[0].u_chan.cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL valid_kick5: got fl=%b cnt=%h want 00 0", FLSTAT[1:0], dut.g_chan[0].u_chan.cnt);
        end
        for (int i = 0; i < 10; i++) begin
            idle(1);
            rst_seen |= RSTOUT[0];
        end
        ctrl(3'd0, 16'h0008);
        rst_seen |= RSTOUT[0];
        n_tests++;
        if (FLSTAT[1:0] !== 2'b00 || dut.g_chan[0].u_chan.cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL valid_kick10: got fl=%b cnt=%h want 00 0", FLSTAT[1:0], dut.g_chan[0].u_chan.cnt);
        end
        n_tests++;
        if (rst_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL valid_no_rst: got %b want 0", rst_seen);
        end
    endtask

    task automatic test_rst_fault();
        int n = 0;
        while (!RSTOUT[0] && n < 20) begin
            idle(1);
            n++;
        end
        n_tests++;
        if (n != 11) begin
            n_fail++;
            $display("FAIL rstf_enter: got %0d cycles want 11", n);
        end
        idle(2);
        RST = 1'b1;
        idle(1);
        n_tests++;
        if ({RSTOUT, WDFAIL, FLSTAT, BROWNOUT} !== 17'h0) begin
            n_fail++;
            $display("FAIL rstf_outputs: got %h want 0", {RSTOUT, WDFAIL, FLSTAT, BROWNOUT});
        end
        RST = 1'b0;
        idle(1);
        drive(ABUS_IDLE, 16'hAAAA);
        drive(ABUS_IDLE, 16'h1111);
        drive(ABUS_IDLE, 16'h5555);
        for (int i = 0; i < 4; i++) drive({3'd1, REG_FRAME}, 16'h0033);
        n_tests++;
        if (dut.g_chan[1].u_chan.frame !== 16'h0000) begin
            n_fail++;
            $display("FAIL bad_unlock: got frame=%h want 0000", dut.g_chan[1].u_chan.frame);
        end
    endtask

    task automatic test_brownout();
        unlock();
        drive({3'd0, REG_FRAME}, 16'h0040);
        drive({3'd1, REG_FRAME}, 16'h0040);
        idle(2);
        ctrl(3'd0, 16'h0010);
        ctrl(3'd1, 16'h0010);
        ADC_IN = 20'h10000;
        idle(3);
        n_tests++;
        if (BROWNOUT !== 1'b0) begin
            n_fail++;
            $display("FAIL bo_3cyc: got %b want 0", BROWNOUT);
        end
        idle(1);
        n_tests++;
        if (BROWNOUT !== BO_EN) begin
            n_fail++;
            $display("FAIL bo_set: got %b want %b", BROWNOUT, BO_EN);
        end
        n_tests++;
        if (FLSTAT !== (BO_EN ? 8'h0F : 8'h00) || RSTOUT !== (BO_EN ? 4'b0011 : 4'b0000)) begin
            n_fail++;
            $display("FAIL bo_fault: got fl=%b rst=%b want %b %b", FLSTAT, RSTOUT,
                     BO_EN ? 8'h0F : 8'h00, BO_EN ? 4'b0011 : 4'b0000);
        end
        ADC_IN = 20'h90000;
        idle(3);
        n_tests++;
        if (BROWNOUT !== BO_EN) begin
            n_fail++;
            $display("FAIL bo_hold: got %b want %b", BROWNOUT, BO_EN);
        end
        idle(1);
        n_tests++;
        if (BROWNOUT !== 1'b0) begin
            n_fail++;
            $display("FAIL bo_clear: got %b want 0", BROWNOUT);
        end
    endtask

    initial begin
        test_reset();
        test_config();
        test_late();
        test_early();
        test_valid();
        test_rst_fault();
        test_brownout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
